frog_mover: RTL and testbench
=============================

Name: frog_mover

Overview:
- Player-side writer of the frog position on the 16x16 LED board. Produces `frog_row` (consumed by the victory checker) and the green frog pixel plane.
- Converts four direction keys into single-step moves.
- Reacts to the checker's registered `victory` and to the collision `hit` input by freezing, scoring, and respawning the frog.
- Also tracks lives and game-over.

Parameters:
- `ROWS`, 16, board rows; row 0 is the far (winning) side.
- `COLS`, 16, board columns.
- `START_ROW`, 15, respawn row.
- `START_COL`, 7, respawn column.
- `HOLD_CYCLES`, 50000000, frozen cycles after a win or death (≥1).
- `LIVES`, 3, lives reloaded at reset and at game-over exit (1..7).

Ports:
- `clk`  in  1  system clock
- `reset_n`  in  1  asynchronous active-low reset
- `key_up`, `key_down`, `key_left`, `key_right`  in  1 each  synchronised active-high key levels
- `victory`  in  1  registered win flag from the checker; high one cycle after `frog_row == 0`
- `hit`  in  1  frog overlaps a car this cycle
- `frog_row`  out  4  current row
- `frog_col`  out  4  current column
- `GreenPixels`  out  [15:0][15:0]  one-hot frog plane; bit [`frog_row`][`frog_col`] set, all others 0
- `frozen`  out  1  high in any state other than PLAY
- `respawn`  out  1  one-cycle pulse when the frog returns to start
- `score`  out  8  wins, saturating at 255
- `lives`  out  3  remaining lives
- `game_over`  out  1  high in state OVER

Behaviour:
- Reset (async, `reset_n` = 0):
  - Position outputs: `frog_row` = `START_ROW`, `frog_col` = `START_COL`, `GreenPixels` = that single bit.
  - Status outputs: `score` = 0, `lives` = `LIVES`, `frozen` = 0, `respawn` = 0, `game_over` = 0.
  - Internal: state = PLAY; key history registers = all 1s, so keys held through reset cause no move.
- Key edges:
  - press_x = key_x & ~key_x_q.
  - Priority up > down > left > right; lower-priority presses in the same cycle are dropped.
  - At most one move per cycle.
- PLAY moves, registered with 1-cycle latency:
  - up: `frog_row` − 1, saturating at 0.
  - down: `frog_row` + 1, saturating at `ROWS`−1.
  - left/right: `frog_col` ∓ 1, saturating at 0 / `COLS`−1.
- `GreenPixels` is registered together with the position, so both update on the same edge.
- PLAY → WIN_HOLD:
  - Condition: `victory` = 1 AND `frog_row` == 0. Requiring row 0 rejects the stale `victory` seen in the cycle after a respawn.
  - Actions: `score` += 1 (saturating); hold counter loaded with `HOLD_CYCLES`−1.
- PLAY → DEAD_HOLD:
  - Condition: `hit` = 1 with no qualifying victory. Victory wins over a simultaneous hit.
  - Actions: `lives` −= 1; counter loaded.
- A move and a transition in the same cycle: the transition wins and the move is discarded.
- WIN_HOLD / DEAD_HOLD:
  - Keys, `hit` and `victory` are ignored; the counter decrements each cycle.
  - When the counter is 0: frog set to start and `respawn` = 1 for that one cycle.
  - Next state is PLAY, or OVER if `lives` == 0.
  - `HOLD_CYCLES` = 1 gives exactly one frozen cycle.
- OVER:
  - Frog stays at start; `game_over` = 1.
  - Any key press → PLAY with `lives` = `LIVES`, `score` = 0. No move is applied for that press.
- Reset asserted mid-hold or in OVER: immediate return to the reset values.

Optional Feature:
- Macro: `FROG_WRAP_EN`.
- Defined: left from column 0 goes to `COLS`−1, and right from `COLS`−1 goes to 0. Rows still saturate.
- Undefined: columns saturate as described above.

Decomposition:
- Package `frog_pkg`:
  - `ROWS`/`COLS` constants.
  - `frog_state_t` enum {PLAY, WIN_HOLD, DEAD_HOLD, OVER}.
  - `move_t` enum {NONE, UP, DOWN, LEFT, RIGHT}.
- Sub-module `key_edge_detect`: 4-bit registered edge detector (history registers reset to 1s) plus priority encoding to `move_t`.

Test Plan:
- Reset with `key_up` held, then release and press up once → no move at reset; `frog_row` 15→14 one cycle after the press; `GreenPixels`[14][7] = 1, popcount 1.
- 15 up presses, then a `victory` pulse one cycle after `frog_row` = 0 → `frozen` = 1, `score` = 1. After `HOLD_CYCLES`: `respawn` pulses once, frog at (15, 7). A `victory` held one extra cycle after respawn is ignored.
- Left ×8 from column 7 → column 0 and stays at 0 (with `FROG_WRAP_EN`: 7 presses reach 0, the 8th gives column 15). Up+left pressed in the same cycle → only `frog_row` changes.
- `hit` three times with `LIVES` = 3 → `lives` 2, 1, 0. After the third hold: `game_over` = 1. A key press then gives `lives` = 3, `score` = 0, frog still at (15, 7).
- `victory` and `hit` in the same cycle at row 0 → WIN_HOLD, `score` +1, `lives` unchanged.
- `reset_n` pulsed low mid-WIN_HOLD → outputs return immediately (asynchronously) to reset values; `frozen` = 0.

Source files
------------

// File: rtl/frog_pkg.sv
// frog_pkg: shared board constants, FSM state and move encodings for the frog mover.
// Contents: ROWS/COLS, frog_state_t, move_t, pixel_of() one-hot plane helper.
// Used by: frog_mover, key_edge_detect.
package frog_pkg;

  localparam int ROWS = 16;
  localparam int COLS = 16;

  typedef enum logic [1:0] {
    PLAY      = 2'd0,
    WIN_HOLD  = 2'd1,
    DEAD_HOLD = 2'd2,
    OVER      = 2'd3
  } frog_state_t;

  typedef enum logic [2:0] {
    NONE  = 3'd0,
    UP    = 3'd1,
    DOWN  = 3'd2,
    LEFT  = 3'd3,
    RIGHT = 3'd4
  } move_t;

  // Single lit pixel at [row][col] on the 16x16 board.
  function automatic logic [15:0][15:0] pixel_of(input logic [3:0] row, input logic [3:0] col);
    logic [15:0][15:0] p;
    p = '0;
    p[row][col] = 1'b1;
    return p;
  endfunction

endpackage

// File: rtl/key_edge_detect.sv
// key_edge_detect: rising-edge detector on four direction keys with priority encoding.
// Ports: clk, reset_n (async active-low), i_keys {up,down,left,right}, o_move (combinational).
// History resets to all 1s so keys held through reset produce no press.
module key_edge_detect
  import frog_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] i_keys,
  output move_t      o_move
);

  logic [3:0] r_keys_q;
  logic [3:0] w_press;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_keys_q <= 4'hF;
    end else begin
      r_keys_q <= i_keys;
    end
  end

  assign w_press = i_keys & ~r_keys_q;

  // up > down > left > right; lower-priority presses in the same cycle are dropped
  always_comb begin
    o_move = NONE;
    if (w_press[3])      o_move = UP;
    else if (w_press[2]) o_move = DOWN;
    else if (w_press[1]) o_move = LEFT;
    else if (w_press[0]) o_move = RIGHT;
  end

endmodule

// File: rtl/frog_mover.sv
// frog_mover: frog position, pixel plane, score/lives and win/death/game-over FSM.
// Ports: clk, reset_n, key_up/down/left/right, victory, hit -> frog_row, frog_col,
//   GreenPixels, frozen, respawn, score, lives, game_over. All outputs registered.
// Optional macro FROG_WRAP_EN: columns wrap around instead of saturating.
module frog_mover #(
  parameter int ROWS        = frog_pkg::ROWS,
  parameter int COLS        = frog_pkg::COLS,
  parameter int START_ROW   = 15,
  parameter int START_COL   = 7,
  parameter int HOLD_CYCLES = 50000000,
  parameter int LIVES       = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              key_up,
  input  logic              key_down,
  input  logic              key_left,
  input  logic              key_right,
  input  logic              victory,
  input  logic              hit,
  output logic [3:0]        frog_row,
  output logic [3:0]        frog_col,
  output logic [15:0][15:0] GreenPixels,
  output logic              frozen,
  output logic              respawn,
  output logic [7:0]        score,
  output logic [2:0]        lives,
  output logic              game_over
);
  import frog_pkg::*;

  localparam logic [3:0]  ROW_MAX   = 4'(ROWS - 1);
  localparam logic [3:0]  COL_MAX   = 4'(COLS - 1);
  localparam logic [3:0]  ROW_START = 4'(START_ROW);
  localparam logic [3:0]  COL_START = 4'(START_COL);
  localparam logic [31:0] HOLD_LOAD = 32'(HOLD_CYCLES - 1);
  localparam logic [2:0]  LIVES_INIT = 3'(LIVES);

  frog_state_t       r_state;
  logic [3:0]        r_row;
  logic [3:0]        r_col;
  logic [15:0][15:0] r_pixels;
  logic              r_frozen;
  logic              r_respawn;
  logic [7:0]        r_score;
  logic [2:0]        r_lives;
  logic              r_game_over;
  logic [31:0]       r_cnt;

  move_t      w_move;
  logic [3:0] w_row_nxt;
  logic [3:0] w_col_nxt;

  key_edge_detect u_keys (
    .clk     (clk),
    .reset_n (reset_n),
    .i_keys  ({key_up, key_down, key_left, key_right}),
    .o_move  (w_move)
  );

  // Candidate position if the move is applied in PLAY.
  always_comb begin
    w_row_nxt = r_row;
    w_col_nxt = r_col;
    case (w_move)
      UP:    if (r_row != 4'd0)    w_row_nxt = r_row - 4'd1;
      DOWN:  if (r_row != ROW_MAX) w_row_nxt = r_row + 4'd1;
`ifdef FROG_WRAP_EN
      LEFT:  w_col_nxt = (r_col == 4'd0)    ? COL_MAX : r_col - 4'd1;
      RIGHT: w_col_nxt = (r_col == COL_MAX) ? 4'd0    : r_col + 4'd1;
`else
      LEFT:  if (r_col != 4'd0)    w_col_nxt = r_col - 4'd1;
      RIGHT: if (r_col != COL_MAX) w_col_nxt = r_col + 4'd1;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= PLAY;
      r_row       <= ROW_START;
      r_col       <= COL_START;
      r_pixels    <= pixel_of(ROW_START, COL_START);
      r_frozen    <= 1'b0;
      r_respawn   <= 1'b0;
      r_score     <= 8'd0;
      r_lives     <= LIVES_INIT;
      r_game_over <= 1'b0;
      r_cnt       <= 32'd0;
    end else begin
      r_respawn <= 1'b0;
      case (r_state)
        PLAY: begin
          // Row-0 qualification rejects the stale victory seen right after a respawn.
          if (victory && r_row == 4'd0) begin
            r_state  <= WIN_HOLD;
            r_frozen <= 1'b1;
            r_score  <= (r_score == 8'd255) ? r_score : r_score + 8'd1;
            r_cnt    <= HOLD_LOAD;
          end else if (hit) begin
            r_state  <= DEAD_HOLD;
            r_frozen <= 1'b1;
            r_lives  <= (r_lives == 3'd0) ? 3'd0 : r_lives - 3'd1;
            r_cnt    <= HOLD_LOAD;
          end else begin
            r_row    <= w_row_nxt;
            r_col    <= w_col_nxt;
            r_pixels <= pixel_of(w_row_nxt, w_col_nxt);
          end
        end
        WIN_HOLD, DEAD_HOLD: begin
          if (r_cnt == 32'd0) begin
            r_row     <= ROW_START;
            r_col     <= COL_START;
            r_pixels  <= pixel_of(ROW_START, COL_START);
            r_respawn <= 1'b1;
            if (r_lives == 3'd0) begin
              r_state     <= OVER;
              r_game_over <= 1'b1;
            end else begin
              r_state  <= PLAY;
              r_frozen <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt - 32'd1;
          end
        end
        OVER: begin
          // The restarting press is consumed; no move is applied for it.
          if (w_move != NONE) begin
            r_state     <= PLAY;
            r_frozen    <= 1'b0;
            r_game_over <= 1'b0;
            r_lives     <= LIVES_INIT;
            r_score     <= 8'd0;
          end
        end
        default: r_state <= PLAY;
      endcase
    end
  end

  assign frog_row    = r_row;
  assign frog_col    = r_col;
  assign GreenPixels = r_pixels;
  assign frozen      = r_frozen;
  assign respawn     = r_respawn;
  assign score       = r_score;
  assign lives       = r_lives;
  assign game_over   = r_game_over;

endmodule

// File: tb/tb_frog_mover.sv
// tb_frog_mover: directed stimulus with a cycle-level game model and per-cycle compare.
// Ports: none; drives frog_mover with HOLD_CYCLES=3, LIVES=3.
// Honours FROG_WRAP_EN in the model and literal expectations.
module tb_frog_mover;

  localparam int HOLD   = 3;
  localparam int NLIVES = 3;

  logic clk = 1'b0;
  logic reset_n, key_up, key_down, key_left, key_right, victory, hit;
  logic [3:0]        frog_row, frog_col;
  logic [15:0][15:0] GreenPixels;
  logic              frozen, respawn, game_over;
  logic [7:0]        score;
  logic [2:0]        lives;

  always #5 clk = ~clk;

  frog_mover #(.HOLD_CYCLES(HOLD), .LIVES(NLIVES)) dut (
    .clk(clk), .reset_n(reset_n),
    .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
    .victory(victory), .hit(hit),
    .frog_row(frog_row), .frog_col(frog_col), .GreenPixels(GreenPixels),
    .frozen(frozen), .respawn(respawn), .score(score), .lives(lives), .game_over(game_over)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Game model: mode 0 = playing, 1 = frozen hold, 2 = game over.
  int m_row, m_col, m_score, m_lives, m_mode, m_left;
  bit m_resp;
  logic [3:0] m_prev;

  task automatic model_reset();
    m_row = 15; m_col = 7; m_score = 0; m_lives = NLIVES;
    m_mode = 0; m_left = 0; m_resp = 1'b0; m_prev = 4'hF;
  endtask

  always @(posedge clk or negedge reset_n) begin
    logic [3:0] keys;
    logic [3:0] pr;
    if (!reset_n) begin
      model_reset();
    end else begin
      keys   = {key_up, key_down, key_left, key_right};
      pr     = keys & ~m_prev;
      m_prev = keys;
      m_resp = 1'b0;
      if (m_mode == 0) begin
        if (victory && m_row == 0) begin
          m_mode = 1; m_left = HOLD;
          m_score = (m_score < 255) ? m_score + 1 : 255;
        end else if (hit) begin
          m_mode = 1; m_left = HOLD; m_lives = m_lives - 1;
        end else if (pr[3]) m_row = (m_row > 0) ? m_row - 1 : 0;
        else if (pr[2])     m_row = (m_row < 15) ? m_row + 1 : 15;
`ifdef FROG_WRAP_EN
        else if (pr[1])     m_col = (m_col > 0) ? m_col - 1 : 15;
        else if (pr[0])     m_col = (m_col < 15) ? m_col + 1 : 0;
`else
        else if (pr[1])     m_col = (m_col > 0) ? m_col - 1 : 0;
        else if (pr[0])     m_col = (m_col < 15) ? m_col + 1 : 15;
`endif
      end else if (m_mode == 1) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_row = 15; m_col = 7; m_resp = 1'b1;
          m_mode = (m_lives == 0) ? 2 : 0;
        end
      end else begin
        if (pr != 4'd0) begin
          m_mode = 0; m_lives = NLIVES; m_score = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [255:0] ep;
    if (chk_en) begin
      ep = '0;
      ep[m_row * 16 + m_col] = 1'b1;
      check("row",       256'(frog_row),  256'(m_row));
      check("col",       256'(frog_col),  256'(m_col));
      check("pixels",    256'(GreenPixels), ep);
      check("frozen",    256'(frozen),    256'(m_mode != 0));
      check("respawn",   256'(respawn),   256'(m_resp));
      check("score",     256'(score),     256'(m_score));
      check("lives",     256'(lives),     256'(m_lives));
      check("game_over", 256'(game_over), 256'(m_mode == 2));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // k: 3 up, 2 down, 1 left, 0 right
  task automatic press(input int k);
    case (k)
      3: key_up = 1'b1;
      2: key_down = 1'b1;
      1: key_left = 1'b1;
      default: key_right = 1'b1;
    endcase
    tick(1);
    key_up = 1'b0; key_down = 1'b0; key_left = 1'b0; key_right = 1'b0;
    tick(1);
  endtask

  initial begin
    reset_n = 1'b0; key_up = 1'b1; key_down = 1'b0; key_left = 1'b0; key_right = 1'b0;
    victory = 1'b0; hit = 1'b0;
    tick(2);
    chk_en = 1'b1;
    check("rst_row",       256'(frog_row), 256'(15));
    check("rst_col",       256'(frog_col), 256'(7));
    check("rst_score",     256'(score), 256'(0));
    check("rst_lives",     256'(lives), 256'(3));
    check("rst_frozen",    256'(frozen), 256'(0));
    check("rst_game_over", 256'(game_over), 256'(0));
    check("rst_pix_15_7",  256'(GreenPixels[15][7]), 256'(1));

    reset_n = 1'b1;
    tick(2);
    check("held_key_no_move", 256'(frog_row), 256'(15));
    key_up = 1'b0; tick(1);
    key_up = 1'b1; tick(1);
    check("first_up_row", 256'(frog_row), 256'(14));
    check("first_up_pix", 256'(GreenPixels[14][7]), 256'(1));
    check("first_up_popcount", 256'($countones(GreenPixels)), 256'(1));
    key_up = 1'b0; tick(1);

    repeat (15) press(3);
    check("top_row_saturate", 256'(frog_row), 256'(0));
    victory = 1'b1; tick(1);
    check("win_frozen", 256'(frozen), 256'(1));
    check("win_score",  256'(score), 256'(1));
    tick(2);
    check("win_still_frozen", 256'(frozen), 256'(1));
    tick(1);
    check("win_respawn", 256'(respawn), 256'(1));
    check("win_respawn_row", 256'(frog_row), 256'(15));
    tick(1);
    check("stale_victory_frozen", 256'(frozen), 256'(0));
    check("stale_victory_score",  256'(score), 256'(1));
    victory = 1'b0; tick(1);

    repeat (8) press(1);
`ifdef FROG_WRAP_EN
    check("left_x8_col", 256'(frog_col), 256'(15));
`else
    check("left_x8_col", 256'(frog_col), 256'(0));
`endif
    key_up = 1'b1; key_left = 1'b1; tick(1);
    check("up_left_row", 256'(frog_row), 256'(14));
`ifdef FROG_WRAP_EN
    check("up_left_col", 256'(frog_col), 256'(15));
`else
    check("up_left_col", 256'(frog_col), 256'(0));
`endif
    key_up = 1'b0; key_left = 1'b0; tick(1);

    for (int i = 0; i < 3; i++) begin
      hit = 1'b1; tick(1);
      hit = 1'b0;
      check("hit_lives", 256'(lives), 256'(2 - i));
      tick(HOLD);
    end
    check("over_game_over", 256'(game_over), 256'(1));
    check("over_frozen", 256'(frozen), 256'(1));
    check("over_col", 256'(frog_col), 256'(7));
    key_right = 1'b1; tick(1);
    check("restart_lives", 256'(lives), 256'(3));
    check("restart_score", 256'(score), 256'(0));
    check("restart_col_no_move", 256'(frog_col), 256'(7));
    check("restart_game_over", 256'(game_over), 256'(0));
    key_right = 1'b0; tick(1);

    repeat (15) press(3);
    victory = 1'b1; hit = 1'b1; tick(1);
    check("vic_hit_score", 256'(score), 256'(1));
    check("vic_hit_lives", 256'(lives), 256'(3));
    check("vic_hit_frozen", 256'(frozen), 256'(1));
    victory = 1'b0; hit = 1'b0;
    tick(1);
    reset_n = 1'b0; #1;
    check("async_rst_frozen", 256'(frozen), 256'(0));
    check("async_rst_score", 256'(score), 256'(0));
    check("async_rst_row", 256'(frog_row), 256'(15));
    check("async_rst_col", 256'(frog_col), 256'(7));
    check("async_rst_lives", 256'(lives), 256'(3));
    tick(2);
    reset_n = 1'b1;
    tick(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
